// File: rtl/pipe_pkg.sv
// Shared defaults and the channel entry payload for the two-way tagged demux.
package pipe_pkg;

    localparam int unsigned WIDTH_DEF = 32;
    localparam int unsigned TAG_W_DEF = 4;
    localparam int unsigned DEPTH_DEF = 2;

    typedef struct packed {
        logic [WIDTH_DEF-1:0] data;
        logic [TAG_W_DEF-1:0] tag;
    } chan_entry_t;

    // Occupancy counter width able to represent 0..depth inclusive.
    function automatic int unsigned count_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/chan_fifo.sv
// Per-channel in-order buffer with wrap-around pointers and synchronous flush.
module chan_fifo #(
    parameter int unsigned ENTRY_W = 36,
    parameter int unsigned DEPTH   = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [ENTRY_W-1:0]           push_entry,
    output logic [ENTRY_W-1:0]           entry,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               push_ok;
    logic               pop_ok;
    logic               wr_en;

    // Advance a pointer, wrapping at DEPTH (not at the next power of two).
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign push_ok = push && !full;
    assign pop_ok  = pop && (count_q != '0);
    assign wr_en   = push_ok && !flush;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_ok) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop_ok) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (wr_en) begin
                mem_q[wr_ptr_q] <= push_entry;
            end
        end
    end

    assign entry = mem_q[rd_ptr_q];
    assign count = count_q;

endmodule

// File: rtl/demux_2_reg.sv
// Two-way tagged demux: each accepted word is buffered in channel a or b by in_sel.
module demux_2_reg
    import pipe_pkg::*;
#(
    parameter int unsigned WIDTH = WIDTH_DEF,
    parameter int unsigned TAG_W = TAG_W_DEF,
    parameter int unsigned DEPTH = DEPTH_DEF
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    input  logic [TAG_W-1:0]           in_tag,
    input  logic                       in_sel,
    output logic                       a_valid,
    input  logic                       a_ready,
    output logic [WIDTH-1:0]           a_data,
    output logic [TAG_W-1:0]           a_tag,
    output logic                       b_valid,
    input  logic                       b_ready,
    output logic [WIDTH-1:0]           b_data,
    output logic [TAG_W-1:0]           b_tag,
    output logic [$clog2(DEPTH+1)-1:0] a_count,
    output logic [$clog2(DEPTH+1)-1:0] b_count
);

    localparam int unsigned ENTRY_W = WIDTH + TAG_W;

    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [TAG_W-1:0] tag;
    } entry_t;

    entry_t in_entry;
    entry_t a_head;
    entry_t b_head;
    logic   a_full;
    logic   b_full;
    logic   accept;
    logic   a_push;
    logic   b_push;

    // Readiness depends only on the selected channel's occupancy, never on a_ready/b_ready.
    assign in_ready = !rst && !flush && (in_sel ? !a_full : !b_full);
    assign accept   = in_valid && in_ready;
    assign a_push   = accept && in_sel;
    assign b_push   = accept && !in_sel;
    assign in_entry = '{data: in_data, tag: in_tag};

    chan_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_chan_a (
        .clk        (clk),
        .rst        (rst),
        .push       (a_push),
        .pop        (a_ready),
        .flush      (flush),
        .push_entry (in_entry),
        .entry      (a_head),
        .count      (a_count),
        .full       (a_full)
    );

    chan_fifo #(
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_chan_b (
        .clk        (clk),
        .rst        (rst),
        .push       (b_push),
        .pop        (b_ready),
        .flush      (flush),
        .push_entry (in_entry),
        .entry      (b_head),
        .count      (b_count),
        .full       (b_full)
    );

    assign a_valid = (a_count != '0);
    assign a_data  = a_head.data;
    assign a_tag   = a_head.tag;
    assign b_valid = (b_count != '0);
    assign b_data  = b_head.data;
    assign b_tag   = b_head.tag;

endmodule

// File: tb/tb_demux_2_reg.sv
// Directed vector bench for demux_2_reg at default parameters (WIDTH=32, TAG_W=4, DEPTH=2).
module tb_demux_2_reg;
    import pipe_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [3:0]  in_tag;
    logic        in_sel;
    logic        a_valid;
    logic        a_ready;
    logic [31:0] a_data;
    logic [3:0]  a_tag;
    logic        b_valid;
    logic        b_ready;
    logic [31:0] b_data;
    logic [3:0]  b_tag;
    logic [1:0]  a_count;
    logic [1:0]  b_count;

    int checks;
    int failures;

    demux_2_reg #(
        .WIDTH (32),
        .TAG_W (4),
        .DEPTH (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_tag   (in_tag),
        .in_sel   (in_sel),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .a_data   (a_data),
        .a_tag    (a_tag),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .b_data   (b_data),
        .b_tag    (b_tag),
        .a_count  (a_count),
        .b_count  (b_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        flush;
        logic        in_valid;
        logic        in_sel;
        chan_entry_t in_e;
        logic        a_ready;
        logic        b_ready;
        logic        exp_ready;
        logic        exp_av;
        chan_entry_t exp_a;
        logic [1:0]  exp_ac;
        logic        exp_bv;
        chan_entry_t exp_b;
        logic [1:0]  exp_bc;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input logic fl, input logic iv, input logic sel,
        input logic [31:0] d, input logic [3:0] t,
        input logic ar, input logic br, input logic rdy,
        input logic av, input logic [31:0] ad, input logic [3:0] at, input logic [1:0] ac,
        input logic bv, input logic [31:0] bd, input logic [3:0] bt, input logic [1:0] bc);
        vec_t v;
        v.flush     = fl;
        v.in_valid  = iv;
        v.in_sel    = sel;
        v.in_e      = '{data: d, tag: t};
        v.a_ready   = ar;
        v.b_ready   = br;
        v.exp_ready = rdy;
        v.exp_av    = av;
        v.exp_a     = '{data: ad, tag: at};
        v.exp_ac    = ac;
        v.exp_bv    = bv;
        v.exp_b     = '{data: bd, tag: bt};
        v.exp_bc    = bc;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_idle();
        flush    = 1'b0;
        in_valid = 1'b0;
        in_sel   = 1'b1;
        in_data  = '0;
        in_tag   = '0;
        a_ready  = 1'b0;
        b_ready  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        drive_idle();

        // a: fill, block, full+pop, push+pop with wrap; b accepted while a is full
        vecs.push_back(mk(0,0,1, 32'h0,0,        0,0, 1, 0,32'h0,0,0,        0,32'h0,0,0));
        vecs.push_back(mk(0,1,1, 32'h11111111,3, 0,0, 1, 1,32'h11111111,3,1, 0,32'h0,0,0));
        vecs.push_back(mk(0,1,1, 32'h22222222,5, 0,0, 1, 1,32'h11111111,3,2, 0,32'h0,0,0));
        vecs.push_back(mk(0,1,1, 32'h33333333,6, 0,0, 0, 1,32'h11111111,3,2, 0,32'h0,0,0));
        vecs.push_back(mk(0,1,0, 32'hAAAA0001,1, 0,0, 1, 1,32'h11111111,3,2, 1,32'hAAAA0001,1,1));
        vecs.push_back(mk(0,1,1, 32'h44444444,8, 1,0, 0, 1,32'h22222222,5,1, 1,32'hAAAA0001,1,1));
        vecs.push_back(mk(0,1,1, 32'h55555555,7, 1,0, 1, 1,32'h55555555,7,1, 1,32'hAAAA0001,1,1));
        vecs.push_back(mk(0,0,1, 32'h0,0,        1,0, 1, 0,32'h0,0,0,        1,32'hAAAA0001,1,1));
        vecs.push_back(mk(0,0,1, 32'h0,0,        1,0, 1, 0,32'h0,0,0,        1,32'hAAAA0001,1,1));
        // flush wins over a same-cycle push and pop
        vecs.push_back(mk(1,1,0, 32'hDEADBEEF,9, 0,1, 0, 0,32'h0,0,0,        0,32'h0,0,0));
        vecs.push_back(mk(0,0,0, 32'h0,0,        1,1, 1, 0,32'h0,0,0,        0,32'h0,0,0));
        // b ordering
        vecs.push_back(mk(0,1,0, 32'h1,2,        0,0, 1, 0,32'h0,0,0,        1,32'h1,2,1));
        vecs.push_back(mk(0,1,0, 32'h2,4,        0,0, 1, 0,32'h0,0,0,        1,32'h1,2,2));
        vecs.push_back(mk(0,0,0, 32'h0,0,        0,1, 0, 0,32'h0,0,0,        1,32'h2,4,1));
        vecs.push_back(mk(0,0,0, 32'h0,0,        0,1, 1, 0,32'h0,0,0,        0,32'h0,0,0));
        // b full does not block a
        vecs.push_back(mk(0,1,0, 32'hB1,1,       0,0, 1, 0,32'h0,0,0,        1,32'hB1,1,1));
        vecs.push_back(mk(0,1,0, 32'hB2,2,       0,0, 1, 0,32'h0,0,0,        1,32'hB1,1,2));
        vecs.push_back(mk(0,1,1, 32'hA5,5,       0,0, 1, 1,32'hA5,5,1,       1,32'hB1,1,2));
        vecs.push_back(mk(1,0,1, 32'h0,0,        0,0, 0, 0,32'h0,0,0,        0,32'h0,0,0));

        repeat (2) @(posedge clk);
        #1;
        check("rst_a_valid", 64'(a_valid), 64'(0));
        check("rst_b_valid", 64'(b_valid), 64'(0));
        check("rst_a_count", 64'(a_count), 64'(0));
        check("rst_b_count", 64'(b_count), 64'(0));
        check("rst_a_data",  64'(a_data),  64'(0));
        check("rst_b_tag",   64'(b_tag),   64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(0));
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            flush    = vecs[i].flush;
            in_valid = vecs[i].in_valid;
            in_sel   = vecs[i].in_sel;
            in_data  = vecs[i].in_e.data;
            in_tag   = vecs[i].in_e.tag;
            a_ready  = vecs[i].a_ready;
            b_ready  = vecs[i].b_ready;
            @(negedge clk);
            check($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_a_valid", i), 64'(a_valid), 64'(vecs[i].exp_av));
            check($sformatf("v%0d_a_count", i), 64'(a_count), 64'(vecs[i].exp_ac));
            check($sformatf("v%0d_b_valid", i), 64'(b_valid), 64'(vecs[i].exp_bv));
            check($sformatf("v%0d_b_count", i), 64'(b_count), 64'(vecs[i].exp_bc));
            if (vecs[i].exp_av) begin
                check($sformatf("v%0d_a_data", i), 64'(a_data), 64'(vecs[i].exp_a.data));
                check($sformatf("v%0d_a_tag", i),  64'(a_tag),  64'(vecs[i].exp_a.tag));
            end
            if (vecs[i].exp_bv) begin
                check($sformatf("v%0d_b_data", i), 64'(b_data), 64'(vecs[i].exp_b.data));
                check($sformatf("v%0d_b_tag", i),  64'(b_tag),  64'(vecs[i].exp_b.tag));
            end
        end

        // No same-cycle bypass: a stays invalid until the edge after accept.
        drive_idle();
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'h66;
        in_tag   = 4'h6;
        #1;
        check("bypass_a_valid_pre", 64'(a_valid), 64'(0));
        @(posedge clk);
        #1;
        check("lat_a_valid", 64'(a_valid), 64'(1));
        check("lat_a_data",  64'(a_data),  64'(32'h66));
        in_sel  = 1'b0;
        in_data = 32'h77;
        in_tag  = 4'h7;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("pre_rst_b_count", 64'(b_count), 64'(1));
        check("pre_rst_a_count", 64'(a_count), 64'(1));

        // Reset pulsed between edges clears state immediately and loses the words.
        #2;
        rst = 1'b1;
        #1;
        check("async_a_valid", 64'(a_valid), 64'(0));
        check("async_b_valid", 64'(b_valid), 64'(0));
        check("async_a_count", 64'(a_count), 64'(0));
        check("async_b_count", 64'(b_count), 64'(0));
        check("async_a_data",  64'(a_data),  64'(0));
        check("async_in_ready", 64'(in_ready), 64'(0));
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_a_valid", 64'(a_valid), 64'(0));
        check("post_rst_b_valid", 64'(b_valid), 64'(0));
        in_valid = 1'b1;
        in_sel   = 1'b1;
        in_data  = 32'h99;
        in_tag   = 4'h1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        check("post_rst_push_a_count", 64'(a_count), 64'(1));
        check("post_rst_push_a_data",  64'(a_data),  64'(32'h99));
        check("post_rst_push_a_tag",   64'(a_tag),   64'(1));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_2_reg.md
DEMUX_2_REG -- requirements
Module: demux_2_reg

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, meaning data width.
REQ-002 The block SHALL have parameter TAG_W, default 4, meaning the routing tag width carried with each word.
REQ-003 The block SHALL have parameter DEPTH, default 2, meaning per-channel buffer entries (legal range 2..8).
REQ-004 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-005 The block SHALL have port clk, input, 1, the clock; all state changes on its rising edge.
REQ-006 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port flush, input, 1, synchronous clear of both channel buffers.
REQ-008 The block SHALL have port in_valid, input, 1, meaning the upstream word is valid.
REQ-009 The block SHALL have port in_ready, output, 1, meaning the word is accepted this cycle.
REQ-010 The block SHALL have port in_data, input, WIDTH, the upstream word.
REQ-011 The block SHALL have port in_tag, input, TAG_W, the word tag.
REQ-012 The block SHALL have port in_sel, input, 1; 1 routes to channel a and 0 to channel b.
REQ-013 The block SHALL have ports a_valid (output, 1), a_ready (input, 1), a_data (output, WIDTH) and a_tag (output, TAG_W) for channel a.
REQ-014 The block SHALL have ports b_valid, b_ready, b_data and b_tag, identical to channel a, for channel b.
REQ-015 The block SHALL have ports a_count and b_count, output, clog2(DEPTH+1), giving the occupancy of each channel.

Function
REQ-016 Accept SHALL occur when in_valid, in_ready and no flush hold at the clock edge; the word and tag SHALL be pushed into the channel selected by in_sel.
REQ-017 in_ready SHALL equal !flush && (in_sel ? a_count<DEPTH : b_count<DEPTH), with no combinational dependence on a_ready or b_ready.
REQ-018 Each channel SHALL be an in-order FIFO; x_valid SHALL equal x_count!=0, and x_data and x_tag SHALL show the oldest entry.
REQ-019 A pop SHALL occur when x_valid and x_ready hold at the clock edge.
REQ-020 Latency from accept to x_valid SHALL be exactly 1 cycle; there is no same-cycle bypass.
REQ-021 A simultaneous push and pop on one channel SHALL leave its count unchanged and preserve order.
REQ-022 When full, a push SHALL NOT occur (in_ready=0), even if that channel pops the same cycle.
REQ-023 A pop when empty SHALL have no effect.
REQ-024 Pointers SHALL wrap modulo DEPTH.
REQ-025 Flush SHALL set both counts and pointers to 0 at the edge, overriding any same-cycle push or pop; x_valid SHALL be 0 the next cycle.
REQ-026 The two channels SHALL be independent; stalling one SHALL NOT block words routed to the other.
REQ-027 x_data and x_tag SHALL hold stable while x_valid && !x_ready.

Reset
REQ-028 On rst=1 (asynchronous), all counts and pointers SHALL be 0, a_valid and b_valid SHALL be 0, and x_data and x_tag SHALL be 0.
REQ-029 in_ready SHALL be 0 while rst=1, and buffered words SHALL be lost on reset mid-operation.
REQ-030 Deassertion of rst SHALL take effect on the next clk edge, with no accept in the deassert cycle's preceding edge.

Structure
REQ-031 WIDTH and TAG_W defaults and a channel entry struct {data, tag} SHALL live in shared package pipe_pkg.
REQ-032 One sub-module, chan_fifo (push, pop, flush, entry, count, full), SHALL be instantiated twice.
REQ-033 No latches SHALL be inferred, and all sequential logic SHALL use nonblocking assignment.

Verification
REQ-034 Route: sel=1, data=0x11111111, tag=3 -> next cycle a_valid=1, a_data=0x11111111, a_tag=3, b_valid=0.
REQ-035 Backpressure: a_ready=0, push 3 words to a -> a_count=2, in_ready=0 for sel=1, in_ready=1 for sel=0, and a b-push is accepted.
REQ-036 Order: push 0x1, 0x2 to b, then pop with b_ready=1 -> b_data sequence 0x1, 0x2, with b_count returning to 0.
REQ-037 Full plus pop: a full, a_ready=1, in_valid sel=1 -> no accept that cycle, and a_count goes to 1.
REQ-038 Flush with concurrent push -> both counts 0 next cycle and the pushed word is never emitted.
REQ-039 Asynchronous reset mid-stream with rst pulsed between edges -> a_valid, b_valid and counts are immediately 0.
